ground_scroller: RTL and testbench
==================================

GROUND_SCROLLER -- requirements
Module: ground_scroller

Interface
REQ-001 Parameters SHALL be:
- Y_TOP, default 465, first ground row.
- Y_BOT, default 479, last ground row.
- STRIPE_W, default 16, stripe width in pixels, power of two, 2..64.
- SPD_W, default 3, width of the speed input.
REQ-002 Ports SHALL be:
- clk  in  1  pixel clock.
- reset  in  1  synchronous active-high reset.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- frame_tick  in  1  one-cycle pulse, once per frame, in vblank.
- start  in  1  one-cycle pulse, begin or restart scrolling.
- speed  in  SPD_W  pixels scrolled per frame.
- bird_bot  in  10  bird bottom row.
- ground_on  out  1  pixel lies in the ground band.
- stripe  out  1  colour select: 0 dark, 1 light.
- hit  out  1  bird has touched the ground.
- scrolling  out  1  state is SCROLL.
REQ-003 Clock and reset SHALL be one clock; reset is synchronous and active-high.

Function
REQ-004 ground_on SHALL be registered: it equals (Y_TOP <= y <= Y_BOT) sampled one cycle earlier.
REQ-005 stripe SHALL be registered: it equals bit log2(STRIPE_W) of (x + offset), sampled one cycle earlier; stripe SHALL be 0 whenever ground_on is 0.
REQ-006 x + offset SHALL be computed 11 bits wide, with no truncation before the bit select.
REQ-007 offset SHALL be an internal counter, range 0..2*STRIPE_W-1.
REQ-008 On frame_tick in SCROLL, offset SHALL become (offset + speed) mod 2*STRIPE_W, wrapping with no skipped or held value.
REQ-009 speed = 0 in SCROLL SHALL leave offset unchanged.
REQ-010 speed > 2*STRIPE_W SHALL still wrap correctly (true modulo, not a single subtract).
REQ-011 The FSM SHALL have three states: IDLE, SCROLL, CRASH.
REQ-012 IDLE -> SCROLL on start.
REQ-013 SCROLL -> CRASH on frame_tick when bird_bot >= Y_TOP; offset is not advanced on that tick.
REQ-014 CRASH -> SCROLL on start; offset SHALL clear to 0 and hit SHALL clear on the same edge.
REQ-015 start while in SCROLL SHALL be ignored.
REQ-016 start and frame_tick in the same cycle SHALL perform the transition only; no offset advance that cycle.
REQ-017 hit SHALL be 1 exactly while in CRASH.
REQ-018 scrolling SHALL be 1 exactly while in SCROLL.
REQ-019 The collision test SHALL be evaluated only on frame_tick; bird_bot changes between ticks have no effect.
REQ-020 offset SHALL be frozen in IDLE and CRASH; the ground still renders with the frozen offset.

Reset
REQ-021 reset SHALL set state = IDLE, offset = 0, ground_on = 0, stripe = 0, hit = 0, scrolling = 0 on the next clk edge.
REQ-022 reset SHALL take priority over start and frame_tick in the same cycle.
REQ-023 reset asserted mid-frame or in CRASH SHALL behave identically to power-up reset.

Structure
REQ-024 The state enum ground_state_t and the screen constants (H_ACTIVE 640, V_ACTIVE 480) SHALL live in shared package flappy_pkg.
REQ-025 The block SHALL be a single module with no sub-modules; the offset counter and FSM are inline.
REQ-026 An elaboration-time check SHALL reject a STRIPE_W that is not a power of two or Y_TOP > Y_BOT.

Verification
REQ-027 Reset, then y=470, x=0 -> ground_on=1 one cycle later; y=464 -> 0; y=465 and y=479 -> 1; y=480 -> 0.
REQ-028 start, speed=3, 11 frame_ticks, bird_bot=100 -> offset sequence 3,6,...,30,1 (wrap at 32); scrolling=1 throughout.
REQ-029 Offset 5, y=470, x=10 -> x+offset=15, stripe=0; x=11 -> 16, stripe=1.
REQ-030 SCROLL, bird_bot=465 at frame_tick -> hit=1 and state CRASH next cycle, offset held; start -> hit=0, offset=0, SCROLL.
REQ-031 start and frame_tick together in IDLE with speed=4 -> SCROLL, offset stays 0; next frame_tick -> offset 4.
REQ-032 reset asserted in CRASH together with start -> IDLE, hit=0, offset=0; a start one cycle later -> SCROLL.

Source files
------------

// File: rtl/flappy_pkg.sv
// +----------------------------------------------------------------------+
// | flappy_pkg : screen constants and ground scroller state encoding      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package flappy_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef enum logic [1:0] {
      GS_IDLE   = 2'd0,
      GS_SCROLL = 2'd1,
      GS_CRASH  = 2'd2
   } ground_state_t;

endpackage

`default_nettype wire

// File: rtl/ground_scroller.sv
// +----------------------------------------------------------------------+
// | ground_scroller : striped scrolling ground band with crash detection  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module ground_scroller
   import flappy_pkg::*;
#(
   parameter int Y_TOP    = 465,
   parameter int Y_BOT    = 479,
   parameter int STRIPE_W = 16,
   parameter int SPD_W    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       x,
   input  logic [9:0]       y,
   input  logic             frame_tick,
   input  logic             start,
   input  logic [SPD_W-1:0] speed,
   input  logic [9:0]       bird_bot,
   output logic             ground_on,
   output logic             stripe,
   output logic             hit,
   output logic             scrolling
);

   localparam int          STRIPE_LOG = $clog2(STRIPE_W);
   localparam int          OFS_W      = STRIPE_LOG + 1;
   localparam int          SUM_W      = ((SPD_W > OFS_W) ? SPD_W : OFS_W) + 1;
   localparam logic [9:0]  Y_TOP_L    = 10'(Y_TOP);
   localparam logic [9:0]  Y_BOT_L    = 10'(Y_BOT);

   if ((STRIPE_W < 2) || (STRIPE_W > 64) ||
       ((STRIPE_W & (STRIPE_W - 1)) != 0) || (Y_TOP > Y_BOT)) begin : g_bad_param
      $error("ground_scroller: STRIPE_W must be a power of two in 2..64 and Y_TOP <= Y_BOT");
   end

   ground_state_t    state_q, state_d;
   logic [OFS_W-1:0] offset_q, offset_d;
   logic             ground_on_q, ground_on_d;
   logic             stripe_q, stripe_d;

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      case (state_q)
         GS_IDLE: begin
            if (start) begin
               state_d  = GS_SCROLL;
               offset_d = '0;
            end
         end
         GS_SCROLL: begin
            // start is ignored here; only the frame tick matters
            if (frame_tick) begin
               if (bird_bot >= Y_TOP_L) begin
                  state_d = GS_CRASH;
               end else begin
                  offset_d = OFS_W'((SUM_W'(offset_q) + SUM_W'(speed)) %
                                    SUM_W'(2 * STRIPE_W));
               end
            end
         end
         GS_CRASH: begin
            if (start) begin
               state_d  = GS_SCROLL;
               offset_d = '0;
            end
         end
         default: begin
            state_d  = GS_IDLE;
            offset_d = '0;
         end
      endcase
   end

   // Stripe colour is the STRIPE_W bit of the full 11-bit scrolled column
   always_comb begin
      ground_on_d = (y >= Y_TOP_L) && (y <= Y_BOT_L);
      stripe_d    = ground_on_d &&
                    ((({1'b0, x} + 11'(offset_q)) & 11'(STRIPE_W)) != 11'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= GS_IDLE;
         offset_q    <= '0;
         ground_on_q <= 1'b0;
         stripe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         ground_on_q <= ground_on_d;
         stripe_q    <= stripe_d;
      end
   end

   assign ground_on = ground_on_q;
   assign stripe    = stripe_q;
   assign hit       = (state_q == GS_CRASH);
   assign scrolling = (state_q == GS_SCROLL);

endmodule

`default_nettype wire

// File: tb/tb_ground_scroller.sv
// +----------------------------------------------------------------------+
// | tb_ground_scroller : scoreboard bench for ground_scroller             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ground_scroller;

   localparam int SPD_W = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic [9:0]       x;
   logic [9:0]       y;
   logic             frame_tick;
   logic             start;
   logic [SPD_W-1:0] speed;
   logic [9:0]       bird_bot;
   logic             ground_on;
   logic             stripe;
   logic             hit;
   logic             scrolling;

   always #5 clk = ~clk;

   ground_scroller #(
      .Y_TOP(465), .Y_BOT(479), .STRIPE_W(16), .SPD_W(SPD_W)
   ) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
      .start(start), .speed(speed), .bird_bot(bird_bot),
      .ground_on(ground_on), .stripe(stripe), .hit(hit), .scrolling(scrolling)
   );

   // expected bits are {ground_on, stripe, hit, scrolling}
   typedef struct {
      logic [3:0] exp;
      string      name;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   initial begin
      exp_t       it;
      logic [3:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            it  = q.pop_front();
            act = {ground_on, stripe, hit, scrolling};
            checks++;
            if (act !== it.exp) begin
               errors++;
               $display("FAIL %s: got g/s/h/sc=%b required %b at %0t",
                        it.name, act, it.exp, $time);
            end
         end
      end
   end

   task automatic cyc(input logic [3:0] e, input string nm);
      exp_t it;
      it.exp  = e;
      it.name = nm;
      q.push_back(it);
      @(negedge clk);
      frame_tick = 1'b0;
      start      = 1'b0;
      reset      = 1'b0;
   endtask

   function automatic logic exp_stripe(input int xv, input int off);
      int s;
      s = xv + off;
      return s[4];
   endfunction

   // Sweep one full stripe period on a ground row; this pins the offset exactly
   task automatic scan(input int off, input logic h, input logic sc, input string nm);
      for (int i = 0; i < 32; i++) begin
         y = 10'd470;
         x = 10'(i);
         cyc({1'b1, exp_stripe(i, off), h, sc}, nm);
      end
      y = 10'd0;
      x = 10'd0;
   endtask

   task automatic tick(input int spd, input int bb, input logic [3:0] e, input string nm);
      speed      = SPD_W'(spd);
      bird_bot   = 10'(bb);
      frame_tick = 1'b1;
      cyc(e, nm);
   endtask

   initial begin
      reset = 1'b1; x = '0; y = 10'd470; frame_tick = 1'b0; start = 1'b0;
      speed = '0; bird_bot = 10'd100;
      @(negedge clk);

      reset = 1'b1; start = 1'b1; frame_tick = 1'b1; y = 10'd470;
      cyc(4'b0000, "reset_prio");
      reset = 1'b1; y = 10'd470;
      cyc(4'b0000, "reset_state");

      y = 10'd470; x = 10'd0;  cyc(4'b1000, "band_470");
      y = 10'd464;             cyc(4'b0000, "band_464");
      y = 10'd465;             cyc(4'b1000, "band_465");
      y = 10'd479;             cyc(4'b1000, "band_479");
      y = 10'd480;             cyc(4'b0000, "band_480");
      y = 10'd470; x = 10'd16; cyc(4'b1100, "idle_x16");
      y = 10'd0;   x = 10'd0;

      speed = SPD_W'(3); start = 1'b1;
      cyc(4'b0001, "start_idle");
      for (int k = 1; k <= 11; k++) begin
         tick(3, 100, 4'b0001, "tick_spd3");
         scan((3 * k) % 32, 1'b0, 1'b1, $sformatf("offset_%0d", (3 * k) % 32));
      end

      tick(4, 100, 4'b0001, "tick_to5");
      y = 10'd470; x = 10'd10; cyc(4'b1001, "off5_x10");
      y = 10'd470; x = 10'd11; cyc(4'b1101, "off5_x11");
      y = 10'd0;   x = 10'd0;

      tick(0, 100, 4'b0001, "tick_spd0");
      y = 10'd470; x = 10'd10; cyc(4'b1001, "spd0_x10");
      y = 10'd470; x = 10'd11; cyc(4'b1101, "spd0_x11");
      y = 10'd0;   x = 10'd0;

      tick(40, 100, 4'b0001, "tick_spd40");
      scan(13, 1'b0, 1'b1, "offset_13_big_speed");

      start = 1'b1;
      cyc(4'b0001, "start_in_scroll");
      scan(13, 1'b0, 1'b1, "start_ignored");

      bird_bot = 10'd470;
      cyc(4'b0001, "bird_low_no_tick");
      tick(3, 100, 4'b0001, "tick_to16");
      scan(16, 1'b0, 1'b1, "offset_16");

      tick(3, 465, 4'b0010, "crash_465");
      scan(16, 1'b1, 1'b0, "crash_frozen");
      tick(3, 100, 4'b0010, "tick_in_crash");
      scan(16, 1'b1, 1'b0, "crash_still_frozen");

      start = 1'b1;
      cyc(4'b0001, "restart");
      scan(0, 1'b0, 1'b1, "restart_offset0");

      reset = 1'b1;
      cyc(4'b0000, "reset_scroll");
      speed = SPD_W'(4); start = 1'b1; frame_tick = 1'b1;
      cyc(4'b0001, "start_and_tick");
      scan(0, 1'b0, 1'b1, "start_tick_no_adv");
      tick(4, 100, 4'b0001, "tick_after_start");
      scan(4, 1'b0, 1'b1, "offset_4");

      tick(4, 479, 4'b0010, "crash_479");
      reset = 1'b1; start = 1'b1;
      cyc(4'b0000, "reset_in_crash");
      scan(0, 1'b0, 1'b0, "idle_after_crash_reset");
      start = 1'b1;
      cyc(4'b0001, "start_after_reset");

      cyc(4'b0001, "final");
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
